// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, registered level and edge strobes.
// Optional long-press strobe is compiled in with `define DEBOUNCE_LONG_PRESS_EN.
module button_debouncer #(
   parameter int CNT_WIDTH       = 20,
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int LONG_WIDTH      = 26,
   parameter int LONG_CYCLES     = 32500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic long_press
);

   typedef enum logic [1:0] {
      IDLE_LOW    = 2'd0,
      WAIT_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      WAIT_LOW    = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 r_s1;
   logic                 r_s2;
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 w_level_nxt;
   logic                 w_rise_nxt;
   logic                 w_fall_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_state   <= IDLE_LOW;
         r_cnt     <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
         btn_fall  <= 1'b0;
      end else begin
         r_s1      <= btn_raw;
         r_s2      <= r_s1;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         btn_level <= w_level_nxt;
         btn_rise  <= w_rise_nxt;
         btn_fall  <= w_fall_nxt;
      end
   end

   // Counter restarts at 1 on every new deviation, so it tops out at DEBOUNCE_CYCLES-1.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         IDLE_LOW: begin
            if (r_s2) begin
               w_state_nxt = WAIT_HIGH;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!r_s2) begin
               w_state_nxt = IDLE_LOW;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE_HIGH;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!r_s2) begin
               w_state_nxt = WAIT_LOW;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (r_s2) begin
               w_state_nxt = STABLE_HIGH;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE_LOW;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE_LOW;
         end
      endcase
      w_level_nxt = (w_state_nxt == STABLE_HIGH) || (w_state_nxt == WAIT_LOW);
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_CYCLES - 1);
   localparam logic [LONG_WIDTH-1:0] LONG_PRE  = LONG_WIDTH'(LONG_CYCLES - 2);
   localparam logic [LONG_WIDTH-1:0] LONG_ONE  = LONG_WIDTH'(1);

   logic [LONG_WIDTH-1:0] r_long_cnt;
   logic                  w_long_run;

   // Counter freezes at LONG_CYCLES-1 so only one strobe fires per press.
   assign w_long_run = ((r_state == STABLE_HIGH) || (r_state == WAIT_LOW)) &&
                       (r_long_cnt != LONG_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_long_cnt <= '0;
         long_press <= 1'b0;
      end else if (w_rise_nxt) begin
         r_long_cnt <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= w_long_run && (r_long_cnt == LONG_PRE);
         if (w_long_run) begin
            r_long_cnt <= r_long_cnt + LONG_ONE;
         end
      end
   end
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: press, bounce, release, reset-in-wait, long press, back-to-back.
module tb_button_debouncer;
  localparam int CW = 3;
  localparam int DC = 4;
  localparam int LW = 4;
  localparam int LC = 10;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic long_press;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  int rise_cnt = 0;
  int fall_cnt = 0;
  int long_cnt = 0;
  int both_cnt = 0;
  int seq_err = 0;
  int last_strobe = 0;
  int last_rise_edge = 0;
  int long_edge = 0;

  button_debouncer #(
    .CNT_WIDTH(CW),
    .DEBOUNCE_CYCLES(DC),
    .LONG_WIDTH(LW),
    .LONG_CYCLES(LC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Advance n rising edges; inputs set afterwards are captured at the next edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) last_strobe = 0;
    if (btn_rise && btn_fall) both_cnt++;
    if (btn_rise) begin
      rise_cnt++;
      last_rise_edge = edge_n;
      if (last_strobe == 1) seq_err++;
      last_strobe = 1;
    end
    if (btn_fall) begin
      fall_cnt++;
      if (last_strobe != 1) seq_err++;
      last_strobe = 2;
    end
    if (long_press) begin
      long_cnt++;
      long_edge = edge_n;
    end
  end

  int r0, f0, l0, p;

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    tick(3);
    check("rst_level", btn_level, 0);
    check("rst_rise", btn_rise, 0);
    check("rst_fall", btn_fall, 0);
    check("rst_long", long_press, 0);
    reset = 1'b0;

    // Clean press: captured at edge 10, level/rise after edge 15.
    tick(9 - edge_n);
    btn_raw = 1'b1;
    for (int e = 10; e <= 16; e++) begin
      tick(1);
      check("press_level", btn_level, (e >= 15));
      check("press_rise", btn_rise, (e == 15));
    end
    check("press_rise_edge", last_rise_edge, 15);

    // Clean release: drop captured at edge 40, fall after edge 45.
    tick(39 - edge_n);
    btn_raw = 1'b0;
    for (int e = 40; e <= 46; e++) begin
      tick(1);
      check("rel_level", btn_level, (e < 45));
      check("rel_fall", btn_fall, (e == 45));
    end
    check("rel_rise_total", rise_cnt, 1);
    check("rel_fall_total", fall_cnt, 1);
`ifdef DEBOUNCE_LONG_PRESS_EN
    check("long_count", long_cnt, 1);
    check("long_edge", long_edge, 15 + LC - 1);
`else
    check("long_count_off", long_cnt, 0);
`endif

    // Bounce rejection: runs of 3 never reach the threshold of 4.
    tick(2);
    r0 = rise_cnt;
    f0 = fall_cnt;
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(1);
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bounce_level", btn_level, 0);
    end
    check("bounce_rise", rise_cnt - r0, 0);
    check("bounce_fall", fall_cnt - f0, 0);

    // Reset mid-wait: press captured at P, reset sampled at P+4, rise after P+10.
    r0 = rise_cnt;
    f0 = fall_cnt;
    p = edge_n + 1;
    btn_raw = 1'b1;
    tick(4);
    check("rstw_no_early", rise_cnt - r0, 0);
    reset = 1'b1;
    tick(1);
    check("rstw_level", btn_level, 0);
    check("rstw_rise", btn_rise, 0);
    check("rstw_fall", btn_fall, 0);
    reset = 1'b0;
    for (int e = p + 5; e <= p + 11; e++) begin
      tick(1);
      check("rstw_level_after", btn_level, (e >= p + 10));
      check("rstw_rise_after", btn_rise, (e == p + 10));
    end
    check("rstw_no_fall", fall_cnt - f0, 0);
    btn_raw = 1'b0;
    tick(10);
    check("rstw_released", btn_level, 0);

    // Short hold: level high only ~6 cycles, below the long threshold.
    r0 = rise_cnt;
    f0 = fall_cnt;
    l0 = long_cnt;
    btn_raw = 1'b1;
    tick(6);
    btn_raw = 1'b0;
    tick(10);
    check("short_rise", rise_cnt - r0, 1);
    check("short_fall", fall_cnt - f0, 1);
    check("short_no_long", long_cnt - l0, 0);

    // Back-to-back presses: 6 high / 6 low, four times.
    r0 = rise_cnt;
    f0 = fall_cnt;
    repeat (4) begin
      btn_raw = 1'b1;
      tick(6);
      btn_raw = 1'b0;
      tick(6);
    end
    tick(8);
    check("b2b_rise", rise_cnt - r0, 4);
    check("b2b_fall", fall_cnt - f0, 4);
    check("b2b_level", btn_level, 0);
    check("seq_alternate", seq_err, 0);
    check("never_both", both_cnt, 0);

    // Reset with raw input low: no strobes at all.
    r0 = rise_cnt;
    f0 = fall_cnt;
    l0 = long_cnt;
    reset = 1'b1;
    tick(3);
    check("rstlow_level", btn_level, 0);
    reset = 1'b0;
    tick(10);
    check("rstlow_rise", rise_cnt - r0, 0);
    check("rstlow_fall", fall_cnt - f0, 0);
    check("rstlow_long", long_cnt - l0, 0);
    check("rstlow_level_after", btn_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
